// File: rtl/lsu_pkg.sv
// Shared load/store definitions: op codes, FSM state encoding and op decode helpers.
// Op code layout: bit 3 = store, bit 2 = zero-extend, bits 1:0 = log2(access bytes).
package lsu_pkg;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int LIS_OP_WIDTH   = 4;

    localparam logic [LIS_OP_WIDTH-1:0] LIS_LB  = 4'h0;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LH  = 4'h1;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LW  = 4'h2;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LD  = 4'h3;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LBU = 4'h4;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LHU = 4'h5;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LWU = 4'h6;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_SB  = 4'h8;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_SH  = 4'h9;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_SW  = 4'hA;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_SD  = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    function automatic logic op_is_store(input logic [LIS_OP_WIDTH-1:0] op);
        return op[3];
    endfunction

    function automatic logic [1:0] op_size(input logic [LIS_OP_WIDTH-1:0] op);
        return op[1:0];
    endfunction

    function automatic logic op_legal(input logic [LIS_OP_WIDTH-1:0] op, input logic is_64);
        logic ok;
        ok = 1'b0;
        case (op)
            LIS_LB, LIS_LH, LIS_LW, LIS_LBU, LIS_LHU,
            LIS_SB, LIS_SH, LIS_SW:                    ok = 1'b1;
            LIS_LWU, LIS_LD, LIS_SD:                   ok = is_64;
            default:                                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: request-side checks, byte enables and store replication,
// plus response-side shift and sign/zero extension of the returned word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int NB         = DATA_WIDTH / 8,
    localparam int OFFW       = $clog2(NB)
) (
    input  logic [LIS_OP_WIDTH-1:0] i_req_op,
    input  logic [OFFW-1:0]         i_req_off,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    output logic                    o_misaligned,
    output logic                    o_illegal,
    output logic [NB-1:0]           o_be,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    input  logic [LIS_OP_WIDTH-1:0] i_rsp_op,
    input  logic [OFFW-1:0]         i_rsp_off,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    logic [1:0]            w_size;
    logic [DATA_WIDTH-1:0] w_shifted;

    always_comb begin
        w_size       = op_size(i_req_op);
        o_illegal    = !op_legal(i_req_op, DATA_WIDTH == 64);
        o_misaligned = 1'b0;
        case (w_size)
            2'd1:    o_misaligned = i_req_off[0];
            2'd2:    o_misaligned = (i_req_off & OFFW'(3)) != '0;
            2'd3:    o_misaligned = i_req_off != '0;
            default: o_misaligned = 1'b0;
        endcase
        // An unsupported op reports only the illegal flag.
        if (o_illegal) begin
            o_misaligned = 1'b0;
        end

        case (w_size)
            2'd0: begin
                o_be    = NB'(1) << i_req_off;
                o_wdata = {NB{i_req_wdata[7:0]}};
            end
            2'd1: begin
                o_be    = NB'(3) << i_req_off;
                o_wdata = {(NB/2){i_req_wdata[15:0]}};
            end
            2'd2: begin
                o_be    = NB'(15) << i_req_off;
                o_wdata = {(NB/4){i_req_wdata[31:0]}};
            end
            default: begin
                o_be    = '1;
                o_wdata = i_req_wdata;
            end
        endcase
    end

    always_comb begin
        w_shifted = i_rdata >> {i_rsp_off, 3'b000};
        case (i_rsp_op)
            LIS_LB:  o_rdata = DATA_WIDTH'($signed(w_shifted[7:0]));
            LIS_LH:  o_rdata = DATA_WIDTH'($signed(w_shifted[15:0]));
            LIS_LW:  o_rdata = DATA_WIDTH'($signed(w_shifted[31:0]));
            LIS_LBU: o_rdata = DATA_WIDTH'(w_shifted[7:0]);
            LIS_LHU: o_rdata = DATA_WIDTH'(w_shifted[15:0]);
            LIS_LWU: o_rdata = DATA_WIDTH'(w_shifted[31:0]);
            LIS_LD:  o_rdata = w_shifted;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding access, four-state request/grant/rvalid sequencer.
// Misaligned or unsupported accesses complete locally without touching memory.
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [LIS_OP_WIDTH-1:0]   lis_op_i,
    input  logic [DATA_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      rsp_valid_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      misaligned_o,
    output logic                      illegal_o
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_e r_state;
    lsu_state_e w_next;

    logic [LIS_OP_WIDTH-1:0] r_op;
    logic [OFFW-1:0]         r_off;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NB-1:0]           r_be;
    logic                    r_we;
    logic                    r_mis;
    logic                    r_ill;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_mis;
    logic                    w_ill;
    logic [NB-1:0]           w_be;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH-1:0]   w_ext;
    logic                    w_accept;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .i_req_op     (lis_op_i),
        .i_req_off    (addr_i[OFFW-1:0]),
        .i_req_wdata  (wdata_i),
        .o_misaligned (w_mis),
        .o_illegal    (w_ill),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .i_rsp_op     (r_op),
        .i_rsp_off    (r_off),
        .i_rdata      (mem_rdata_i),
        .o_rdata      (w_ext)
    );

    assign w_accept = req_valid_i && (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        req_ready_o = 1'b0;
        mem_req_o   = 1'b0;
        rsp_valid_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_next = (w_mis || w_ill) ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    w_next = r_we ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                w_next      = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op    <= '0;
            r_off   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
            r_mis   <= 1'b0;
            r_ill   <= 1'b0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_op    <= lis_op_i;
            r_off   <= addr_i[OFFW-1:0];
            r_addr  <= addr_i[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(NB - 1);
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_we    <= op_is_store(lis_op_i);
            r_mis   <= w_mis;
            r_ill   <= w_ill;
            r_rdata <= '0;
        end else if (r_state == ST_WAIT && mem_rvalid_i) begin
            r_rdata <= w_ext;
        end
    end

    // Memory-side outputs are quiet outside REQ so the bus sees nothing from idle or error accesses.
    assign mem_we_o     = mem_req_o & r_we;
    assign mem_be_o     = mem_req_o ? r_be : '0;
    assign mem_addr_o   = mem_req_o ? r_addr : '0;
    assign mem_wdata_o  = mem_req_o ? r_wdata : '0;
    assign rdata_o      = r_rdata;
    assign misaligned_o = rsp_valid_o & r_mis;
    assign illegal_o    = rsp_valid_o & r_ill;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: table of accesses with a response scoreboard, plus reset and 64-bit sequences.
`timescale 1ns/1ps
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  lis_op_i;
    logic [31:0] addr_i, wdata_i;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        rsp_valid_o;
    logic [31:0] rdata_o;
    logic        misaligned_o, illegal_o;

    logic        req_valid_64, req_ready_64;
    logic [3:0]  op_64;
    logic [63:0] addr_64, wdata_64;
    logic        mem_req_64, mem_we_64;
    logic [7:0]  mem_be_64;
    logic [31:0] mem_addr_64;
    logic [63:0] mem_wdata_64;
    logic        mem_gnt_64, mem_rvalid_64;
    logic [63:0] mem_rdata_64;
    logic        rsp_valid_64;
    logic [63:0] rdata_64;
    logic        mis_64, ill_64;

    lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .lis_op_i(lis_op_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rsp_valid_o(rsp_valid_o), .rdata_o(rdata_o),
        .misaligned_o(misaligned_o), .illegal_o(illegal_o)
    );

    lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid_64), .req_ready_o(req_ready_64),
        .lis_op_i(op_64), .addr_i(addr_64), .wdata_i(wdata_64),
        .mem_req_o(mem_req_64), .mem_we_o(mem_we_64), .mem_be_o(mem_be_64),
        .mem_addr_o(mem_addr_64), .mem_wdata_o(mem_wdata_64),
        .mem_gnt_i(mem_gnt_64), .mem_rvalid_i(mem_rvalid_64), .mem_rdata_i(mem_rdata_64),
        .rsp_valid_o(rsp_valid_64), .rdata_o(rdata_64),
        .misaligned_o(mis_64), .illegal_o(ill_64)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] exp_rdata;
        logic        mis;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[18];

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int gnt_dly, input logic [3:0] be,
                                input logic [31:0] mwdata, input logic [31:0] exp_rdata,
                                input logic mis, input logic ill);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.gnt_dly = gnt_dly;
        v.be = be; v.mwdata = mwdata; v.exp_rdata = exp_rdata; v.mis = mis; v.ill = ill;
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstn === 1'b1 && rsp_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", rsp_valid_o, 1'b0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_rdata", rdata_o, e.rdata);
                chk("sb_misaligned", misaligned_o, e.mis);
                chk("sb_illegal", illegal_o, e.ill);
            end
        end
    end

    // Drive one access in the cycle the LSU is idle, play the memory side, check latency.
    task automatic run_vec(input int idx, input vec_t v);
        int  lat, exp_lat, wait_g;
        bit  granted, err;
        err     = v.mis || v.ill;
        exp_lat = err ? 1 : (v.op[3] ? 2 + v.gnt_dly : 3 + v.gnt_dly);
        lat     = -1;
        wait_g  = 0;
        granted = 0;
        chk($sformatf("v%0d ready", idx), req_ready_o, 1'b1);
        req_valid_i = 1'b1;
        lis_op_i    = v.op;
        addr_i      = v.addr;
        wdata_i     = v.wdata;
        sb_q.push_back('{rdata: v.exp_rdata, mis: v.mis, ill: v.ill});
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'hDEAD_DEAD;
            if (err) begin
                chk($sformatf("v%0d noreq", idx), mem_req_o, 1'b0);
            end
            if (rsp_valid_o) begin
                lat = k;
            end else if (mem_req_o) begin
                chk($sformatf("v%0d be", idx), mem_be_o, v.be);
                chk($sformatf("v%0d we", idx), mem_we_o, v.op[3]);
                chk($sformatf("v%0d addr", idx), mem_addr_o, v.addr & 32'hFFFF_FFFC);
                if (v.op[3]) begin
                    chk($sformatf("v%0d wdata", idx), mem_wdata_o, v.mwdata);
                end
                if (wait_g == v.gnt_dly) begin
                    mem_gnt_i = 1'b1;
                    granted   = 1;
                end else begin
                    wait_g++;
                    mem_rvalid_i = 1'b1;   // must be ignored outside WAIT
                end
            end else if (granted) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = v.rdata;
            end
            @(posedge clk); #1;
        end
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        chk($sformatf("v%0d latency", idx), lat, exp_lat);
        chk($sformatf("v%0d rsp_one_cycle", idx), rsp_valid_o, 1'b0);
    endtask

    task automatic run64(input string name, input logic [3:0] op, input logic [63:0] addr,
                         input logic [63:0] rdata, input logic [7:0] be,
                         input logic [63:0] exp_rdata, input logic mis, input logic ill);
        bit got, granted;
        got = 0;
        granted = 0;
        req_valid_64 = 1'b1;
        op_64        = op;
        addr_64      = addr;
        @(posedge clk); #1;
        req_valid_64 = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            mem_gnt_64    = 1'b0;
            mem_rvalid_64 = 1'b0;
            if (rsp_valid_64) begin
                got = 1;
                chk({name, " rdata"}, rdata_64, exp_rdata);
                chk({name, " mis"}, mis_64, mis);
                chk({name, " ill"}, ill_64, ill);
            end else if (mem_req_64) begin
                chk({name, " be"}, mem_be_64, be);
                chk({name, " addr"}, mem_addr_64, addr[31:0] & 32'hFFFF_FFF8);
                mem_gnt_64 = 1'b1;
                granted    = 1;
            end else if (granted) begin
                mem_rvalid_64 = 1'b1;
                mem_rdata_64  = rdata;
            end
            @(posedge clk); #1;
        end
        mem_gnt_64    = 1'b0;
        mem_rvalid_64 = 1'b0;
        chk({name, " rsp_seen"}, got, 1'b1);
    endtask

    initial begin
        req_valid_i = 0; lis_op_i = 0; addr_i = 0; wdata_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        req_valid_64 = 0; op_64 = 0; addr_64 = 0; wdata_64 = 0;
        mem_gnt_64 = 0; mem_rvalid_64 = 0; mem_rdata_64 = 0;
        rstn = 1'b0;
        #1;
        chk("rst ready", req_ready_o, 1'b1);
        chk("rst mem_req", mem_req_o, 1'b0);
        chk("rst be", mem_be_o, 4'h0);
        chk("rst addr", mem_addr_o, 32'h0);
        chk("rst rsp", rsp_valid_o, 1'b0);
        chk("rst rdata", rdata_o, 32'h0);
        chk("rst flags", {misaligned_o, illegal_o}, 2'b00);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        vecs[0]  = mk(LIS_LB,  32'h103, 32'h0,         32'h80FF_1234, 0, 4'b1000, 32'h0,         32'hFFFF_FF80, 0, 0);
        vecs[1]  = mk(LIS_SH,  32'h202, 32'h0000_BEEF, 32'h0,         3, 4'b1100, 32'hBEEF_BEEF, 32'h0,         0, 0);
        vecs[2]  = mk(LIS_LW,  32'h101, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h0,         1, 0);
        vecs[3]  = mk(LIS_LHU, 32'h002, 32'h0,         32'h8001_0000, 0, 4'b1100, 32'h0,         32'h0000_8001, 0, 0);
        vecs[4]  = mk(LIS_SB,  32'h005, 32'h1234_56A5, 32'h0,         0, 4'b0010, 32'hA5A5_A5A5, 32'h0,         0, 0);
        vecs[5]  = mk(LIS_LD,  32'h000, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h0,         0, 1);
        vecs[6]  = mk(LIS_LH,  32'h006, 32'h0,         32'hC001_1234, 2, 4'b1100, 32'h0,         32'hFFFF_C001, 0, 0);
        vecs[7]  = mk(LIS_LH,  32'h003, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h0,         1, 0);
        vecs[8]  = mk(LIS_SW,  32'h008, 32'hDEAD_BEEF, 32'h0,         1, 4'b1111, 32'hDEAD_BEEF, 32'h0,         0, 0);
        vecs[9]  = mk(LIS_LW,  32'h00C, 32'h0,         32'h89AB_CDEF, 0, 4'b1111, 32'h0,         32'h89AB_CDEF, 0, 0);
        vecs[10] = mk(LIS_LBU, 32'h101, 32'h0,         32'h0000_F000, 0, 4'b0010, 32'h0,         32'h0000_00F0, 0, 0);
        vecs[11] = mk(LIS_SW,  32'h006, 32'h1122_3344, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         1, 0);
        vecs[12] = mk(LIS_LWU, 32'h000, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h0,         0, 1);
        vecs[13] = mk(LIS_SD,  32'h000, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h0,         0, 1);
        vecs[14] = mk(4'h7,    32'h000, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h0,         0, 1);
        vecs[15] = mk(LIS_LB,  32'h000, 32'h0,         32'h0000_007F, 0, 4'b0001, 32'h0,         32'h0000_007F, 0, 0);
        vecs[16] = mk(LIS_SH,  32'h001, 32'h0000_1234, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         1, 0);
        vecs[17] = mk(LIS_LH,  32'h000, 32'h0,         32'h1234_8765, 0, 4'b0011, 32'h0,         32'hFFFF_8765, 0, 0);

        foreach (vecs[i]) begin
            run_vec(i, vecs[i]);
        end

        // Reset while the request is waiting for grant: mem_req_o must drop without a clock.
        req_valid_i = 1'b1; lis_op_i = LIS_LW; addr_i = 32'h10;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk("rstreq pre mem_req", mem_req_o, 1'b1);
        rstn = 1'b0;
        #1;
        chk("rstreq mem_req", mem_req_o, 1'b0);
        chk("rstreq ready", req_ready_o, 1'b1);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Reset while waiting for read data; a late rvalid must not produce a response.
        req_valid_i = 1'b1; lis_op_i = LIS_LW; addr_i = 32'h20;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        mem_gnt_i   = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i   = 1'b0;
        chk("rstwait in_wait ready", req_ready_o, 1'b0);
        rstn = 1'b0;
        #1;
        chk("rstwait ready", req_ready_o, 1'b1);
        @(posedge clk); #1;
        rstn = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rstwait no_rsp", rsp_valid_o, 1'b0);
            chk("rstwait idle_ready", req_ready_o, 1'b1);
            @(posedge clk); #1;
        end
        chk("rstwait rdata", rdata_o, 32'h0);
        run_vec(100, vecs[0]);

        run64("d64 lw",  LIS_LW,  64'h4, 64'h8000_0000_0000_0000, 8'hF0, 64'hFFFF_FFFF_8000_0000, 0, 0);
        run64("d64 lwu", LIS_LWU, 64'h4, 64'h8000_0000_0000_0000, 8'hF0, 64'h0000_0000_8000_0000, 0, 0);
        run64("d64 ld",  LIS_LD,  64'h8, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0);
        run64("d64 sd_mis", LIS_SD, 64'h4, 64'h0, 8'h00, 64'h0, 1, 0);

        chk("sb drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
